alu_32: RTL and testbench
=========================

Name: alu_32

Overview:
Registered 32-bit MIPS-style ALU used in the datapath execute stage. It covers AND, OR, NOR, signed ADD, unsigned ADDU, signed SUB and signed SLT. It reports zero, carry-out, overflow and invalid-opcode status. All outputs are registered with one-cycle latency on a single clock, with synchronous active-high reset.

Parameters:
WORD_SIZE, 32, operand/result width (the block must work for any WORD_SIZE >= 2).
CONTROL_AND, 4'b0000, opcode: bitwise AND.
CONTROL_OR, 4'b0001, opcode: bitwise OR.
CONTROL_ADD, 4'b0010, opcode: signed add.
CONTROL_ADD_UNSIGNED, 4'b0011, opcode: unsigned add.
CONTROL_SUB, 4'b0110, opcode: signed subtract (a - b).
CONTROL_SLT, 4'b0111, opcode: signed set-less-than.
CONTROL_NOR, 4'b1100, opcode: bitwise NOR.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous active-high reset (sampled on rising clk edge).
input_a  input  WORD_SIZE  operand A.
input_b  input  WORD_SIZE  operand B.
control  input  4  opcode select.
result  output  WORD_SIZE  registered result.
zero  output  1  registered; 1 when result == 0 for a valid opcode.
cout  output  1  registered carry-out of the MSB adder stage.
err_overflow  output  1  registered overflow flag.
err_invalid_control  output  1  registered; 1 when control is not a defined opcode.
valid  output  1  registered; 1 when the output registers hold a result for a valid opcode.

Behaviour:
- Reset: when rst=1 at a clk edge, result=0, zero=0, cout=0, err_overflow=0, err_invalid_control=0, valid=0. Reset has priority over any inputs. Asserting reset mid-stream discards the in-flight operation.
- Latency: inputs sampled at edge N appear on the outputs after edge N. Throughput is one operation per cycle; there is no handshake.
- The datapath is a single WORD_SIZE adder: sum = a + (sub ? ~b : b) + sub, with carry c_out from the MSB. sub=1 for SUB and SLT.
- AND / OR / NOR: bitwise. cout=0, err_overflow=0.
- ADD: result = a+b mod 2^W. cout = c_out. err_overflow = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
- ADDU: result = a+b mod 2^W. cout = c_out. err_overflow = c_out (unsigned overflow).
- SUB: result = a-b mod 2^W. cout = c_out (1 means no borrow). err_overflow = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
- SLT: result = {0..., lt}, where lt = diff[MSB] XOR signed_overflow(a-b). This is correct across the full signed range. cout=0, err_overflow=0 (SLT never flags overflow).
- zero = (result == 0) for every valid opcode.
- Invalid opcode (any code not listed): result=0, zero=0, cout=0, err_overflow=0, err_invalid_control=1, valid=0.
- Valid opcode: err_invalid_control=0, valid=1.
- No sticky flags; every flag reflects only the most recently registered operation.

Optional Feature:
Macro ALU_SLTU_EN.
- Defined: opcode 4'b1000 (CONTROL_SLTU) is valid. result = 1 if a < b unsigned (equivalently c_out==0 of a-b), else 0. cout=0, err_overflow=0.
- Not defined: 4'b1000 is invalid and follows the invalid-opcode rules.

Test Plan:
1. Hold rst=1 with control=CONTROL_ADD, a=5, b=7 -> all outputs 0, valid=0. Release rst -> next cycle result=12, valid=1, zero=0.
2. ADD: 0x7FFFFFFF+0x1 -> result=0x80000000, err_overflow=1, cout=0. Then 0x80000000+0xFFFFFFFF -> result=0x7FFFFFFF, err_overflow=1, cout=1.
3. ADDU: 0xFFFFFFFF+0x1 -> result=0, zero=1, cout=1, err_overflow=1. Then 1234+4321 -> result=5555 (0x15B3), all flags 0.
4. SUB: 0x80000000-0x1 -> result=0x7FFFFFFF, err_overflow=1, cout=1. Then 1-1 -> result=0, zero=1, cout=1, err_overflow=0. Then 100-101 -> result=0xFFFFFFFF, cout=0, err_overflow=0.
5. SLT: (0xFFFFFFFE, 0xFFFFFFFF) -> 1; (0x0, 0xFFFFFFFF) -> 0; (0x80000000, 0x7FFFFFFF) -> 1; (1, 1) -> 0 with zero=1.
6. Logic and invalid: AND 0x0000FF00 & 0x000000FF -> 0 with zero=1. NOR 0xF, 0xFFFFFFFF -> 0. OR 0x2 | 0x1 -> 0x3. control=4'hF -> err_invalid_control=1, valid=0, result=0.

Source files
------------

// File: rtl/alu_32_if.sv
// alu_32_if: operand/opcode inputs and registered result/status outputs of alu_32
interface alu_32_if #(parameter int WORD_SIZE = 32);
  logic [WORD_SIZE-1:0] input_a;
  logic [WORD_SIZE-1:0] input_b;
  logic [3:0] control;
  logic [WORD_SIZE-1:0] result;
  logic zero;
  logic cout;
  logic err_overflow;
  logic err_invalid_control;
  logic valid;
  modport master (
    output input_a, input_b, control,
    input  result, zero, cout, err_overflow, err_invalid_control, valid
  );
  modport slave (
    input  input_a, input_b, control,
    output result, zero, cout, err_overflow, err_invalid_control, valid
  );
endinterface

// File: rtl/alu_32.sv
// alu_32: registered MIPS-style ALU with zero/carry/overflow/invalid status; ALU_SLTU_EN adds unsigned set-less-than
module alu_32 #(
  parameter int WORD_SIZE = 32,
  parameter logic [3:0] CONTROL_AND = 4'b0000,
  parameter logic [3:0] CONTROL_OR = 4'b0001,
  parameter logic [3:0] CONTROL_ADD = 4'b0010,
  parameter logic [3:0] CONTROL_ADD_UNSIGNED = 4'b0011,
  parameter logic [3:0] CONTROL_SUB = 4'b0110,
  parameter logic [3:0] CONTROL_SLT = 4'b0111,
  parameter logic [3:0] CONTROL_NOR = 4'b1100,
  parameter logic [3:0] CONTROL_SLTU = 4'b1000
) (
  input logic clk,
  input logic rst,
  alu_32_if.slave bus
);
  localparam int W = WORD_SIZE;
  logic [W-1:0] a, b, b_x, sum, res;
  logic [W:0] sum_x;
  logic sub, c_out, ovf_add, ovf_sub, co, ov, ok;
  assign a = bus.input_a;
  assign b = bus.input_b;
`ifdef ALU_SLTU_EN
  assign sub = bus.control == CONTROL_SUB || bus.control == CONTROL_SLT || bus.control == CONTROL_SLTU;
`else
  assign sub = bus.control == CONTROL_SUB || bus.control == CONTROL_SLT;
`endif
  assign b_x = sub ? ~b : b;
  assign sum_x = {1'b0, a} + {1'b0, b_x} + {{W{1'b0}}, sub};
  assign sum = sum_x[W-1:0];
  assign c_out = sum_x[W];
  assign ovf_add = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
  assign ovf_sub = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
  always_comb begin
    res = '0;
    co = 1'b0;
    ov = 1'b0;
    ok = 1'b1;
    case (bus.control)
      CONTROL_AND: res = a & b;
      CONTROL_OR: res = a | b;
      CONTROL_NOR: res = ~(a | b);
      CONTROL_ADD: begin res = sum; co = c_out; ov = ovf_add; end
      CONTROL_ADD_UNSIGNED: begin res = sum; co = c_out; ov = c_out; end
      CONTROL_SUB: begin res = sum; co = c_out; ov = ovf_sub; end
      CONTROL_SLT: res = {{(W-1){1'b0}}, sum[W-1] ^ ovf_sub};
`ifdef ALU_SLTU_EN
      CONTROL_SLTU: res = {{(W-1){1'b0}}, ~c_out};
`endif
      default: ok = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result <= '0;
      bus.zero <= 1'b0;
      bus.cout <= 1'b0;
      bus.err_overflow <= 1'b0;
      bus.err_invalid_control <= 1'b0;
      bus.valid <= 1'b0;
    end else begin
      bus.result <= res;
      bus.zero <= ok && res == '0;
      bus.cout <= co;
      bus.err_overflow <= ov;
      bus.err_invalid_control <= !ok;
      bus.valid <= ok;
    end
  end
endmodule

// File: tb/tb_alu_32.sv
// tb_alu_32: scoreboard-driven self-checking bench for alu_32
module tb_alu_32;
  typedef struct packed {
    logic [31:0] r;
    logic z, c, o, i, v;
  } out_t;
  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_ADDU = 4'b0011;
  localparam logic [3:0] C_SUB = 4'b0110, C_SLT = 4'b0111, C_NOR = 4'b1100, C_SLTU = 4'b1000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  out_t q[$];
  always #5 clk = ~clk;
  alu_32_if #(.WORD_SIZE(32)) bus ();
  alu_32 #(.WORD_SIZE(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic out_t obs();
    return out_t'{bus.result, bus.zero, bus.cout, bus.err_overflow, bus.err_invalid_control, bus.valid};
  endfunction
  function automatic out_t mk(logic [31:0] r, logic z, logic c, logic o, logic i, logic v);
    return out_t'{r, z, c, o, i, v};
  endfunction
  function automatic out_t model(logic [31:0] a, logic [31:0] b, logic [3:0] ctl);
    longint sa, sb, s;
    out_t e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e = '0;
    e.v = 1'b1;
    case (ctl)
      C_AND: e.r = a & b;
      C_OR: e.r = a | b;
      C_NOR: e.r = ~(a | b);
      C_ADD: begin
        s = sa + sb;
        e.r = a + b;
        e.c = (33'(a) + 33'(b)) > 33'h0_FFFF_FFFF;
        e.o = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      C_ADDU: begin
        e.r = a + b;
        e.c = (33'(a) + 33'(b)) > 33'h0_FFFF_FFFF;
        e.o = e.c;
      end
      C_SUB: begin
        s = sa - sb;
        e.r = a - b;
        e.c = a >= b;
        e.o = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      C_SLT: e.r = {31'd0, sa < sb};
`ifdef ALU_SLTU_EN
      C_SLTU: e.r = {31'd0, a < b};
`endif
      default: begin e.i = 1'b1; e.v = 1'b0; end
    endcase
    e.z = e.v && e.r == 32'd0;
    return e;
  endfunction
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl, input out_t e);
    bus.input_a = a;
    bus.input_b = b;
    bus.control = ctl;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    out_t got, exp;
    rst = 1'b1;
    issue(32'd5, 32'd7, C_ADD, mk(32'd0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    got = obs();
    exp = q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_hold got=%h exp=%h", got, exp); end
    rst = 1'b0;
    issue(32'd5, 32'd7, C_ADD, mk(32'd12, 0, 0, 0, 0, 1));
    got = obs();
    exp = q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_release got=%h exp=%h", got, exp); end
  endtask
  task automatic test_arith();
    logic [31:0] av[9] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd1234, 32'h80000000, 32'd1, 32'd100, 32'd0, 32'hFFFFFFFF};
    logic [31:0] bv[9] = '{32'h1, 32'hFFFFFFFF, 32'h1, 32'd4321, 32'h1, 32'd1, 32'd101, 32'd0, 32'hFFFFFFFF};
    logic [3:0] cv[9] = '{C_ADD, C_ADD, C_ADDU, C_ADDU, C_SUB, C_SUB, C_SUB, C_ADD, C_SUB};
    out_t ev[9];
    out_t got, exp;
    ev = '{mk(32'h80000000, 0, 0, 1, 0, 1), mk(32'h7FFFFFFF, 0, 1, 1, 0, 1),
           mk(32'h0, 1, 1, 1, 0, 1), mk(32'h15B3, 0, 0, 0, 0, 1),
           mk(32'h7FFFFFFF, 0, 1, 1, 0, 1), mk(32'h0, 1, 1, 0, 0, 1),
           mk(32'hFFFFFFFF, 0, 0, 0, 0, 1), mk(32'h0, 1, 0, 0, 0, 1),
           mk(32'h0, 1, 1, 0, 0, 1)};
    for (int k = 0; k < 9; k++) begin
      issue(av[k], bv[k], cv[k], ev[k]);
      got = obs();
      exp = q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL arith_%0d got=%h exp=%h", k, got, exp); end
    end
  endtask
  task automatic test_slt();
    logic [31:0] av[5] = '{32'hFFFFFFFE, 32'h0, 32'h80000000, 32'd1, 32'h7FFFFFFF};
    logic [31:0] bv[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd1, 32'h80000000};
    out_t ev[5];
    out_t got, exp;
    ev = '{mk(32'd1, 0, 0, 0, 0, 1), mk(32'd0, 1, 0, 0, 0, 1), mk(32'd1, 0, 0, 0, 0, 1),
           mk(32'd0, 1, 0, 0, 0, 1), mk(32'd0, 1, 0, 0, 0, 1)};
    for (int k = 0; k < 5; k++) begin
      issue(av[k], bv[k], C_SLT, ev[k]);
      got = obs();
      exp = q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL slt_%0d got=%h exp=%h", k, got, exp); end
    end
  endtask
  task automatic test_logic_invalid();
    logic [31:0] av[6] = '{32'h0000FF00, 32'hF, 32'h2, 32'h1234, 32'd1, 32'hFFFFFFFF};
    logic [31:0] bv[6] = '{32'h000000FF, 32'hFFFFFFFF, 32'h1, 32'h5678, 32'd2, 32'h1};
    logic [3:0] cv[6] = '{C_AND, C_NOR, C_OR, 4'hF, C_SLTU, 4'h4};
    out_t ev[6];
    out_t got, exp;
    ev = '{mk(32'h0, 1, 0, 0, 0, 1), mk(32'h0, 1, 0, 0, 0, 1), mk(32'h3, 0, 0, 0, 0, 1),
           mk(32'h0, 0, 0, 0, 1, 0),
`ifdef ALU_SLTU_EN
           mk(32'h1, 0, 0, 0, 0, 1),
`else
           mk(32'h0, 0, 0, 0, 1, 0),
`endif
           mk(32'h0, 0, 0, 0, 1, 0)};
    for (int k = 0; k < 6; k++) begin
      issue(av[k], bv[k], cv[k], ev[k]);
      got = obs();
      exp = q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL logic_inv_%0d got=%h exp=%h", k, got, exp); end
    end
  endtask
  task automatic test_mid_reset();
    out_t got, exp;
    issue(32'h7FFFFFFF, 32'h1, C_ADD, mk(32'h80000000, 0, 0, 1, 0, 1));
    got = obs();
    exp = q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL pre_reset got=%h exp=%h", got, exp); end
    rst = 1'b1;
    issue(32'h3, 32'h4, C_ADD, mk(32'h0, 0, 0, 0, 0, 0));
    got = obs();
    exp = q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_reset got=%h exp=%h", got, exp); end
    rst = 1'b0;
  endtask
  task automatic test_back_to_back();
    logic [3:0] ops[10] = '{C_AND, C_OR, C_ADD, C_ADDU, C_SUB, C_SLT, C_NOR, C_SLTU, 4'h5, 4'hE};
    logic [31:0] corner[4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] a, b;
    logic [3:0] c;
    out_t got, exp;
    for (int k = 0; k < 300; k++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      c = ops[$urandom_range(0, 9)];
      issue(a, b, c, model(a, b, c));
      got = obs();
      exp = q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b_%0d a=%h b=%h op=%h got=%h exp=%h", k, a, b, c, got, exp); end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    bus.input_a = '0;
    bus.input_b = '0;
    bus.control = C_ADD;
    test_reset();
    test_arith();
    test_slt();
    test_logic_invalid();
    test_mid_reset();
    test_back_to_back();
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
